// File: rtl/freq_meter.sv
`timescale 1ns/1ps
// freq_meter: counts synchronized rising edges of sig_in over a GATE_CYCLES-cycle gate window.
// Define PERIOD_MEAS_EN to add edge-to-edge period measurement (period, period_valid).
module freq_meter #(
   parameter int unsigned GATE_CYCLES = 50000000,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sig_in,
   input  logic             enable,
   output logic [CNT_W-1:0] freq,
   output logic             freq_valid,
   output logic             overflow,
   output logic             busy
`ifdef PERIOD_MEAS_EN
   ,
   output logic [CNT_W-1:0] period,
   output logic             period_valid
`endif
);
   localparam int unsigned       GATE_W    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
   localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

   typedef enum logic [1:0] {S_IDLE, S_ARM, S_MEASURE} state_t;

   state_t            state_q, state_d;
   logic              s1_q, s2_q, s3_q;
   logic              edge_det;
   logic [GATE_W-1:0] gate_cnt_q, gate_cnt_d;
   logic [CNT_W-1:0]  edge_cnt_q, edge_cnt_d, edge_cnt_inc;
   logic              sat_q, sat_d, sat_inc;
   logic [CNT_W-1:0]  freq_q, freq_d;
   logic              ovf_q, ovf_d;
   logic              valid_q, valid_d;

   // s1/s2 synchronize sig_in; s3 delays s2 so a 0->1 step yields a single-cycle edge.
   always_ff @(posedge clk) begin
      if (!rst) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
      end else begin
         // NOTE: non-blocking so each flop takes its source's value from before the edge.
         s1_q <= sig_in;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   assign edge_det     = s2_q & ~s3_q;
   assign edge_cnt_inc = (edge_det && (edge_cnt_q != CNT_MAX)) ? edge_cnt_q + 1'b1 : edge_cnt_q;
   assign sat_inc      = sat_q | (edge_cnt_inc == CNT_MAX);

   always_comb begin
      // NOTE: every output of this block gets a default first so no path can infer a latch.
      state_d    = state_q;
      gate_cnt_d = gate_cnt_q;
      edge_cnt_d = edge_cnt_q;
      sat_d      = sat_q;
      freq_d     = freq_q;
      ovf_d      = ovf_q;
      valid_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (enable) state_d = S_ARM;
         end
         S_ARM: begin
            state_d    = S_MEASURE;
            gate_cnt_d = '0;
            edge_cnt_d = '0;
            sat_d      = 1'b0;
         end
         S_MEASURE: begin
            if (!enable) begin
               state_d = S_IDLE;
            end else if (gate_cnt_q == GATE_LAST) begin
               // Close the window including this cycle's edge; the next window starts at once.
               freq_d     = edge_cnt_inc;
               ovf_d      = sat_inc;
               valid_d    = 1'b1;
               gate_cnt_d = '0;
               edge_cnt_d = '0;
               sat_d      = 1'b0;
            end else begin
               gate_cnt_d = gate_cnt_q + 1'b1;
               edge_cnt_d = edge_cnt_inc;
               sat_d      = sat_inc;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         gate_cnt_q <= '0;
         edge_cnt_q <= '0;
         sat_q      <= 1'b0;
         freq_q     <= '0;
         ovf_q      <= 1'b0;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         gate_cnt_q <= gate_cnt_d;
         edge_cnt_q <= edge_cnt_d;
         sat_q      <= sat_d;
         freq_q     <= freq_d;
         ovf_q      <= ovf_d;
         valid_q    <= valid_d;
      end
   end

   assign freq       = freq_q;
   assign freq_valid = valid_q;
   assign overflow   = ovf_q;
   assign busy       = (state_q != S_IDLE);

`ifdef PERIOD_MEAS_EN
   logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic             seen_q, seen_d;
   logic             pval_q, pval_d;

   // per_cnt is 1 on an edge cycle, so the next edge reads the edge-to-edge distance.
   always_comb begin
      per_cnt_d = per_cnt_q;
      seen_d    = seen_q;
      period_d  = period_q;
      pval_d    = 1'b0;
      if (state_q == S_ARM) begin
         per_cnt_d = '0;
         seen_d    = 1'b0;
      end else if ((state_q == S_MEASURE) && enable) begin
         if (edge_det) begin
            if (seen_q) begin
               period_d = per_cnt_q;
               pval_d   = 1'b1;
            end
            per_cnt_d = CNT_W'(1);
            seen_d    = 1'b1;
         end else if (per_cnt_q != CNT_MAX) begin
            per_cnt_d = per_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         per_cnt_q <= '0;
         seen_q    <= 1'b0;
         period_q  <= '0;
         pval_q    <= 1'b0;
      end else begin
         per_cnt_q <= per_cnt_d;
         seen_q    <= seen_d;
         period_q  <= period_d;
         pval_q    <= pval_d;
      end
   end

   assign period       = period_q;
   assign period_valid = pval_q;
`endif
endmodule
